// File: rtl/gps_ack_pkg.sv
// Shared types and constants for the GPS acquisition search scheduler.
package gps_ack_pkg;

  localparam int unsigned PRN_MIN  = 1;
  localparam int unsigned PRN_MAX  = 32;
  localparam int unsigned CODE_LEN = 1023;

  localparam int unsigned SAT_W   = 6;
  localparam int unsigned PHASE_W = 10;
  localparam int unsigned OMEGA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    UPDATE,
    REPORT,
    DONE
  } sched_state_t;

  // One correlation job offered to the correlator.
  typedef struct packed {
    logic [SAT_W-1:0]   sat;
    logic [PHASE_W-1:0] phase;
    logic [OMEGA_W-1:0] omega;
  } job_t;

endpackage

// File: rtl/gps_ack_peak_track.sv
// Per-satellite peak tracker: keeps the strongest {mag, phase, omega} seen since clear.
module gps_ack_peak_track
  import gps_ack_pkg::*;
#(
  parameter int unsigned MAG_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               update,
  input  logic [MAG_W-1:0]   mag,
  input  logic [PHASE_W-1:0] phase,
  input  logic [OMEGA_W-1:0] omega,
  output logic [MAG_W-1:0]   nxt_mag_c,
  output logic [PHASE_W-1:0] nxt_phase_c,
  output logic [OMEGA_W-1:0] nxt_omega_c
);

  logic [MAG_W-1:0]   mag_q,   mag_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [OMEGA_W-1:0] omega_q, omega_d;
  logic               empty_q, empty_d;

  // First job after clear always wins; afterwards only a strictly larger magnitude does.
  always_comb begin
    mag_d   = mag_q;
    phase_d = phase_q;
    omega_d = omega_q;
    empty_d = empty_q;
    if (clear) begin
      mag_d   = '0;
      phase_d = '0;
      omega_d = '0;
      empty_d = 1'b1;
    end else if (update && (empty_q || (mag > mag_q))) begin
      mag_d   = mag;
      phase_d = phase;
      omega_d = omega;
      empty_d = 1'b0;
    end
  end

  assign nxt_mag_c   = mag_d;
  assign nxt_phase_c = phase_d;
  assign nxt_omega_c = omega_d;

  // Peak register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_q   <= '0;
      phase_q <= '0;
      omega_q <= '0;
      empty_q <= 1'b1;
    end else begin
      mag_q   <= mag_d;
      phase_q <= phase_d;
      omega_q <= omega_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: rtl/gps_ack_search_sched.sv
// Acquisition grid walker: satellite / Doppler bin / code phase, one job in flight.
module gps_ack_search_sched
  import gps_ack_pkg::*;
#(
  parameter int unsigned               SAT_FIRST    = PRN_MIN,
  parameter int unsigned               SAT_LAST     = PRN_MAX,
  parameter int unsigned               CODE_PHASES  = CODE_LEN,
  parameter int unsigned               DOPPLER_NUM  = 2,
  parameter logic signed [OMEGA_W-1:0] DOPPLER_INIT = 16'sd13,
  parameter logic signed [OMEGA_W-1:0] DOPPLER_STEP = 16'sd13,
  parameter int unsigned               MAG_W        = 14,
  parameter logic [MAG_W-1:0]          THRESHOLD    = MAG_W'(4000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               cfg_valid,
  input  logic               cfg_ready,
  output logic [SAT_W-1:0]   cfg_sat,
  output logic [PHASE_W-1:0] cfg_code_phase,
  output logic [OMEGA_W-1:0] cfg_doppler_omega,
  input  logic               res_valid,
  input  logic [MAG_W-1:0]   res_mag,
  output logic               rep_valid,
  output logic [SAT_W-1:0]   rep_sat,
  output logic [PHASE_W-1:0] rep_code_phase,
  output logic [OMEGA_W-1:0] rep_doppler_omega,
  output logic [MAG_W-1:0]   rep_mag,
  output logic               rep_detected,
  output logic               search_done,
  output logic               aborted
);

  localparam int unsigned BIN_W = $clog2(DOPPLER_NUM + 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CODE_PHASES - 1);
  localparam logic [BIN_W-1:0]   BIN_LAST   = BIN_W'(DOPPLER_NUM - 1);
  localparam logic [SAT_W-1:0]   SAT_END    = SAT_W'(SAT_LAST);
  localparam job_t JOB_RST = '{sat: SAT_W'(SAT_FIRST), phase: '0, omega: DOPPLER_INIT};

  sched_state_t       state_q, state_d;
  job_t               job_q, job_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic               busy_q, busy_d;
  logic               rep_valid_q, rep_valid_d;
  logic [SAT_W-1:0]   rep_sat_q, rep_sat_d;
  logic [PHASE_W-1:0] rep_phase_q, rep_phase_d;
  logic [OMEGA_W-1:0] rep_omega_q, rep_omega_d;
  logic [MAG_W-1:0]   rep_mag_q, rep_mag_d;
  logic               rep_det_q, rep_det_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               pk_clear, pk_update;
  logic [MAG_W-1:0]   pk_mag_c;
  logic [PHASE_W-1:0] pk_phase_c;
  logic [OMEGA_W-1:0] pk_omega_c;

  gps_ack_peak_track #(.MAG_W(MAG_W)) u_peak (
    .clk         (clk),
    .rst         (rst),
    .clear       (pk_clear),
    .update      (pk_update),
    .mag         (mag_q),
    .phase       (job_q.phase),
    .omega       (job_q.omega),
    .nxt_mag_c   (pk_mag_c),
    .nxt_phase_c (pk_phase_c),
    .nxt_omega_c (pk_omega_c)
  );

  // Next-state, counter stepping and registered output values.
  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    bin_d       = bin_q;
    mag_d       = mag_q;
    rep_sat_d   = rep_sat_q;
    rep_phase_d = rep_phase_q;
    rep_omega_d = rep_omega_q;
    rep_mag_d   = rep_mag_q;
    rep_det_d   = rep_det_q;
    rep_valid_d = 1'b0;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    pk_clear    = 1'b0;
    pk_update   = 1'b0;
    if ((state_q != IDLE) && abort) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = ISSUE;
            job_d    = JOB_RST;
            bin_d    = '0;
            pk_clear = 1'b1;
          end
        end
        ISSUE: begin
          if (cfg_valid_q && cfg_ready) state_d = WAIT;
        end
        WAIT: begin
          if (res_valid) begin
            state_d = UPDATE;
            mag_d   = res_mag;
          end
        end
        UPDATE: begin
          pk_update = 1'b1;
          state_d   = ISSUE;
          if (job_q.phase < PHASE_LAST) begin
            job_d.phase = job_q.phase + PHASE_W'(1);
          end else if (bin_q < BIN_LAST) begin
            job_d.phase = '0;
            job_d.omega = job_q.omega + DOPPLER_STEP;
            bin_d       = bin_q + BIN_W'(1);
          end else begin
            state_d     = REPORT;
            rep_valid_d = 1'b1;
            rep_sat_d   = job_q.sat;
            rep_phase_d = pk_phase_c;
            rep_omega_d = pk_omega_c;
            rep_mag_d   = pk_mag_c;
            rep_det_d   = (pk_mag_c > THRESHOLD);
          end
        end
        REPORT: begin
          if (job_q.sat < SAT_END) begin
            state_d   = ISSUE;
            job_d     = JOB_RST;
            job_d.sat = job_q.sat + SAT_W'(1);
            bin_d     = '0;
            pk_clear  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    cfg_valid_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      job_q       <= JOB_RST;
      bin_q       <= '0;
      mag_q       <= '0;
      cfg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rep_valid_q <= 1'b0;
      rep_sat_q   <= '0;
      rep_phase_q <= '0;
      rep_omega_q <= '0;
      rep_mag_q   <= '0;
      rep_det_q   <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      bin_q       <= bin_d;
      mag_q       <= mag_d;
      cfg_valid_q <= cfg_valid_d;
      busy_q      <= busy_d;
      rep_valid_q <= rep_valid_d;
      rep_sat_q   <= rep_sat_d;
      rep_phase_q <= rep_phase_d;
      rep_omega_q <= rep_omega_d;
      rep_mag_q   <= rep_mag_d;
      rep_det_q   <= rep_det_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign busy              = busy_q;
  assign cfg_valid         = cfg_valid_q;
  assign cfg_sat           = job_q.sat;
  assign cfg_code_phase    = job_q.phase;
  assign cfg_doppler_omega = job_q.omega;
  assign rep_valid         = rep_valid_q;
  assign rep_sat           = rep_sat_q;
  assign rep_code_phase    = rep_phase_q;
  assign rep_doppler_omega = rep_omega_q;
  assign rep_mag           = rep_mag_q;
  assign rep_detected      = rep_det_q;
  assign search_done       = done_q;
  assign aborted           = aborted_q;

endmodule

// File: tb/tb_gps_ack_search_sched.sv
// Bench for gps_ack_search_sched on a 4-phase x 2-bin x 2-satellite grid.
module tb_gps_ack_search_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cfg_ready = 1'b1;
  logic        res_valid;
  logic [13:0] res_mag;
  logic        busy, cfg_valid, rep_valid, rep_detected, search_done, aborted;
  logic [5:0]  cfg_sat, rep_sat;
  logic [9:0]  cfg_code_phase, rep_code_phase;
  logic [15:0] cfg_doppler_omega, rep_doppler_omega;
  logic [13:0] rep_mag;

  gps_ack_search_sched #(
    .SAT_FIRST   (1),
    .SAT_LAST    (2),
    .CODE_PHASES (4),
    .DOPPLER_NUM (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .busy              (busy),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_sat           (cfg_sat),
    .cfg_code_phase    (cfg_code_phase),
    .cfg_doppler_omega (cfg_doppler_omega),
    .res_valid         (res_valid),
    .res_mag           (res_mag),
    .rep_valid         (rep_valid),
    .rep_sat           (rep_sat),
    .rep_code_phase    (rep_code_phase),
    .rep_doppler_omega (rep_doppler_omega),
    .rep_mag           (rep_mag),
    .rep_detected      (rep_detected),
    .search_done       (search_done),
    .aborted           (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          mode;
    logic [9:0]  ph1;
    logic [15:0] om1;
    logic [13:0] mag1;
    logic        det1;
    logic [9:0]  ph2;
    logic [15:0] om2;
    logic [13:0] mag2;
    logic        det2;
  } vec_t;

  int total = 0;
  int bad = 0;
  int mode = 0;
  logic spur_req = 1'b0;
  int jb, rb, db;

  // Records written only by the correlator/monitor process.
  int job_cnt = 0, rep_cnt = 0, done_cnt = 0, abort_cnt = 0;
  logic [5:0]  job_sat_q[$];
  logic [9:0]  job_ph_q[$];
  logic [15:0] job_om_q[$];
  logic [5:0]  rep_sat_q[$];
  logic [9:0]  rep_ph_q[$];
  logic [15:0] rep_om_q[$];
  logic [13:0] rep_mag_q[$];
  logic        rep_det_q[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Correlator response pattern per test mode.
  function automatic logic [13:0] mag_of(int m, logic [5:0] s, logic [9:0] p, logic [15:0] o);
    case (m)
      0: return (s == 6'd1 && p == 10'd2 && o == 16'd26) ? 14'd5000 : 14'd100;
      1: return 14'd4000;
      2: return 14'(1000 * int'(s) + 10 * int'(p) + ((o == 16'd26) ? 5 : 0));
      3: return 14'(4001 + (3 - int'(p)) + ((o == 16'd13) ? 100 : 0));
      4: return ((p == 10'd1 && o == 16'd13) || (p == 10'd2 && o == 16'd26)) ? 14'd4500 : 14'd50;
      default: return 14'd0;
    endcase
  endfunction

  // Correlator model (result 3 cycles after acceptance) plus output monitor.
  initial begin
    int pend = 0;
    logic [5:0]  p_sat = '0;
    logic [9:0]  p_ph = '0;
    logic [15:0] p_om = '0;
    res_valid = 1'b0;
    res_mag   = '0;
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          res_valid = 1'b1;
          res_mag   = mag_of(mode, p_sat, p_ph, p_om);
        end
      end
      if (rst && cfg_valid && cfg_ready && !abort) begin
        job_sat_q.push_back(cfg_sat);
        job_ph_q.push_back(cfg_code_phase);
        job_om_q.push_back(cfg_doppler_omega);
        job_cnt++;
        p_sat = cfg_sat;
        p_ph  = cfg_code_phase;
        p_om  = cfg_doppler_omega;
        pend  = 3;
      end
      if (spur_req) begin
        res_valid = 1'b1;
        res_mag   = 14'd9000;
      end
      if (rep_valid) begin
        rep_sat_q.push_back(rep_sat);
        rep_ph_q.push_back(rep_code_phase);
        rep_om_q.push_back(rep_doppler_omega);
        rep_mag_q.push_back(rep_mag);
        rep_det_q.push_back(rep_detected);
        rep_cnt++;
      end
      if (search_done) done_cnt++;
      if (aborted) abort_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_cfg"}, 64'({busy, cfg_valid, cfg_sat, cfg_code_phase, cfg_doppler_omega}),
          64'({1'b0, 1'b0, 6'd1, 10'd0, 16'd13}));
    check({tag, "_rep"}, 64'({rep_valid, rep_sat, rep_code_phase, rep_doppler_omega, rep_mag,
                              rep_detected, search_done, aborted}), 64'(0));
  endtask

  task automatic begin_run(input int m);
    mode  = m;
    jb    = job_cnt;
    rb    = rep_cnt;
    db    = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_latency", 64'(cfg_valid), 64'(1));
  endtask

  task automatic finish_run(input vec_t v);
    int cyc = 0;
    int errs = 0;
    while (done_cnt == db && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("run_done", 64'(done_cnt - db), 64'(1));
    check("job_count", 64'(job_cnt - jb), 64'(16));
    check("rep_count", 64'(rep_cnt - rb), 64'(2));
    check("busy_after", 64'(busy), 64'(0));
    if (job_cnt - jb >= 16 && rep_cnt - rb >= 2) begin
      for (int i = 0; i < 16; i++) begin
        if (job_sat_q[jb+i] !== 6'(1 + i / 8) || job_ph_q[jb+i] !== 10'(i % 4) ||
            job_om_q[jb+i] !== ((((i / 4) % 2) == 0) ? 16'd13 : 16'd26)) errs++;
      end
      check("issue_order", 64'(errs), 64'(0));
      check("rep1_sat", 64'(rep_sat_q[rb]), 64'(1));
      check("rep1_phase", 64'(rep_ph_q[rb]), 64'(v.ph1));
      check("rep1_omega", 64'(rep_om_q[rb]), 64'(v.om1));
      check("rep1_mag", 64'(rep_mag_q[rb]), 64'(v.mag1));
      check("rep1_det", 64'(rep_det_q[rb]), 64'(v.det1));
      check("rep2_sat", 64'(rep_sat_q[rb+1]), 64'(2));
      check("rep2_phase", 64'(rep_ph_q[rb+1]), 64'(v.ph2));
      check("rep2_omega", 64'(rep_om_q[rb+1]), 64'(v.om2));
      check("rep2_mag", 64'(rep_mag_q[rb+1]), 64'(v.mag2));
      check("rep2_det", 64'(rep_det_q[rb+1]), 64'(v.det2));
    end
  endtask

  initial begin
    vec_t vecs[5];
    logic [31:0] snap;
    int bp_err;
    int cyc;
    int ab0, dc, ac;

    vecs[0] = '{0, 10'd2, 16'd26, 14'd5000, 1'b1, 10'd0, 16'd13, 14'd100,  1'b0};
    vecs[1] = '{1, 10'd0, 16'd13, 14'd4000, 1'b0, 10'd0, 16'd13, 14'd4000, 1'b0};
    vecs[2] = '{2, 10'd3, 16'd26, 14'd1035, 1'b0, 10'd3, 16'd26, 14'd2035, 1'b0};
    vecs[3] = '{3, 10'd0, 16'd13, 14'd4104, 1'b1, 10'd0, 16'd13, 14'd4104, 1'b1};
    vecs[4] = '{4, 10'd1, 16'd13, 14'd4500, 1'b1, 10'd1, 16'd13, 14'd4500, 1'b1};

    // Reset values.
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b1;
    tick();

    // Full grid walks with different result patterns.
    for (int i = 0; i < 5; i++) begin
      begin_run(vecs[i].mode);
      finish_run(vecs[i]);
      tick();
    end

    // Backpressure with a spurious result and a stray start while the offer is held.
    cfg_ready = 1'b0;
    begin_run(0);
    snap   = {cfg_sat, cfg_code_phase, cfg_doppler_omega};
    bp_err = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) spur_req = 1'b1;
      if (i == 3) spur_req = 1'b0;
      if (i == 4) start = 1'b1;
      if (i == 5) start = 1'b0;
      tick();
      if (!cfg_valid || {cfg_sat, cfg_code_phase, cfg_doppler_omega} !== snap) bp_err++;
    end
    check("bp_stable", 64'(bp_err), 64'(0));
    check("bp_fields", 64'(snap), 64'({6'd1, 10'd0, 16'd13}));
    cfg_ready = 1'b1;
    finish_run(vecs[0]);
    tick();

    // Abort while waiting for the sixth result.
    begin_run(0);
    ab0 = abort_cnt;
    cyc = 0;
    while (!((job_cnt - jb) == 6 && !cfg_valid && busy) && cyc < 500) begin
      tick();
      cyc++;
    end
    check("abort_reach", 64'(job_cnt - jb), 64'(6));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_pulse", 64'(aborted), 64'(1));
    repeat (8) tick();
    check("abort_once", 64'(abort_cnt - ab0), 64'(1));
    check("abort_no_rep", 64'(rep_cnt - rb), 64'(0));
    check("abort_no_done", 64'(done_cnt - db), 64'(0));

    // Abort in IDLE does nothing.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("idle_abort", 64'({aborted, busy, cfg_valid}), 64'(0));
    check("idle_abort_cnt", 64'(abort_cnt - ab0), 64'(1));

    // Restart after abort begins again from the first satellite and phase 0.
    begin_run(0);
    finish_run(vecs[0]);
    tick();

    // Asynchronous reset in the middle of a search.
    begin_run(2);
    repeat (20) tick();
    dc  = done_cnt;
    ac  = abort_cnt;
    rst = 1'b0;
    #2;
    check_reset_values("midrst");
    tick();
    rst = 1'b1;
    repeat (6) tick();
    check("midrst_no_pulse", 64'((done_cnt - dc) + (abort_cnt - ac)), 64'(0));
    check("midrst_idle", 64'({busy, cfg_valid}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gps_ack_search_sched.md
Name: gps_ack_search_sched

Overview:
- Search scheduler for the GPS acquisition correlator engine.
- Walks the acquisition grid: outer loop satellite, middle loop Doppler bin, inner loop code phase.
- Issues one correlation job at a time over a valid/ready handshake, then collects the job's magnitude result.
- Tracks the per-satellite peak and emits one report per satellite, with a detection flag set against a threshold.

Parameters:
- SAT_FIRST, 1, first PRN searched (1..32).
- SAT_LAST, 32, last PRN searched (≥SAT_FIRST, ≤32).
- CODE_PHASES, 1023, number of code-phase hypotheses per Doppler bin.
- DOPPLER_NUM, 2, number of Doppler bins per satellite (≥1).
- DOPPLER_INIT, 16'sd13, omega of the first bin (signed 16).
- DOPPLER_STEP, 16'sd13, omega increment per bin (signed 16).
- MAG_W, 14, result magnitude width.
- THRESHOLD, 14'd4000, detection threshold; detection requires peak strictly greater than this value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  begin a search; sampled only in IDLE
- abort  in  1  terminate the search; any state returns to IDLE
- busy  out  1  high whenever state≠IDLE
- cfg_valid  out  1  job offer to the correlator
- cfg_ready  in  1  correlator accepts the job
- cfg_sat  out  6  PRN for the job
- cfg_code_phase  out  10  code phase for the job
- cfg_doppler_omega  out  16  signed carrier NCO omega for the job
- res_valid  in  1  correlator result strobe
- res_mag  in  MAG_W  correlation magnitude
- rep_valid  out  1  one-cycle per-satellite report strobe
- rep_sat  out  6  reported PRN
- rep_code_phase  out  10  phase of the peak
- rep_doppler_omega  out  16  omega of the peak
- rep_mag  out  MAG_W  peak magnitude
- rep_detected  out  1  rep_mag > THRESHOLD
- search_done  out  1  one-cycle pulse when the full grid completes
- aborted  out  1  one-cycle pulse when abort is taken

Behaviour:
- Reset values: all outputs 0, except cfg_sat=SAT_FIRST and cfg_doppler_omega=DOPPLER_INIT. Internal state resets to IDLE.
- States and transitions:
  - IDLE: on start, load sat=SAT_FIRST, bin=0, phase=0, omega=DOPPLER_INIT; clear the peak; go to ISSUE.
  - ISSUE: cfg_valid=1 with registered cfg_* fields. On cfg_valid&&cfg_ready go to WAIT. cfg_* fields hold stable while cfg_valid is high and not yet accepted.
  - WAIT: cfg_valid=0. On res_valid go to UPDATE. A res_valid arriving in any state other than WAIT is ignored.
  - UPDATE (1 cycle): if res_mag > peak_mag, or this is the first job of the satellite, capture {res_mag, phase, omega}. Ties keep the earlier entry. Then step the counters:
    - phase<CODE_PHASES-1: increment phase.
    - Else, if bin<DOPPLER_NUM-1: phase=0, bin++, omega+=DOPPLER_STEP (16-bit wrap, no saturation).
    - Else go to REPORT.
  - After UPDATE, if not going to REPORT, return to ISSUE.
  - REPORT (1 cycle): rep_valid=1 with the peak fields, and rep_detected=(peak_mag>THRESHOLD). Then:
    - sat<SAT_LAST: sat++, bin=0, phase=0, omega=DOPPLER_INIT, clear the peak; go to ISSUE.
    - Else go to DONE.
  - DONE (1 cycle): search_done=1; go to IDLE.
- Latency:
  - start → cfg_valid: 1 cycle.
  - result → next cfg_valid: 2 cycles (UPDATE, then ISSUE).
  - Last result → rep_valid: 2 cycles.
- Only one job is outstanding at any time.
- rep_* fields hold their values until the next report. rep_valid is a pulse.
- Abort:
  - Highest priority, in any non-IDLE state; goes to IDLE the next cycle with aborted=1 for one cycle.
  - No report and no search_done is generated.
  - If abort coincides with cfg_ready, the job is treated as not issued.
  - abort in IDLE has no effect.
- start while busy is ignored.
- If start and abort are both high in IDLE, start wins.
- Asynchronous reset mid-search returns immediately to reset values. No pulse is emitted.
- Parameter boundaries:
  - CODE_PHASES=1: the phase counter never increments.
  - DOPPLER_NUM=1: omega never steps.
  - SAT_FIRST=SAT_LAST: exactly one report.

Decomposition:
- Shared package gps_ack_pkg holds:
  - state enum sched_state_t {IDLE, ISSUE, WAIT, UPDATE, REPORT, DONE};
  - PRN range constants;
  - the code length constant 1023.
- One sub-module, gps_ack_peak_track. It contains:
  - clear/update inputs;
  - the strict-greater compare;
  - the registered peak {mag, phase, omega}.
- The scheduler FSM and counters stay in gps_ack_search_sched.

Test Plan:
- Grid walk with CODE_PHASES=4, DOPPLER_NUM=2, SAT 1..2, cfg_ready=1, result returned 3 cycles after acceptance:
  - exactly 16 accepted jobs;
  - issue order is phase 0..3 at omega 13, then phase 0..3 at omega 26, per satellite;
  - 2 rep_valid pulses, then search_done.
- Peak capture: sat 1 returns mag 100 everywhere except 5000 at phase 2, omega 26 → rep_sat=1, rep_code_phase=2, rep_doppler_omega=26, rep_mag=5000, rep_detected=1.
- Tie and threshold: all results equal 4000 → report phase 0, omega 13, rep_detected=0 (4000 is not > 4000).
- Backpressure: hold cfg_ready=0 for 7 cycles → cfg_valid stays high, fields are stable, and no counter advances.
- Abort:
  - abort in WAIT → aborted pulse, busy=0 next cycle, no rep_valid or search_done;
  - a later start restarts from SAT_FIRST, phase 0.
- Spurious and edge stimuli:
  - res_valid while in ISSUE is ignored;
  - start while busy is ignored;
  - rst low mid-search → all outputs return to reset values asynchronously.
